// File: rtl/cordic_iter.sv
// cordic_iter: iterative CORDIC engine, one micro-rotation per clock.
//   Rotation mode (mode=0) rotates (x_in,y_in) by z_in degrees.
//   Vectoring mode (mode=1) drives y to zero; z_out returns atan2(y,x).
//   Angles are signed with LSB = 2^-8 degree. Gain K ~ 1.6468 is not removed.
// Ports:
//   CLK            rising-edge clock
//   reset_n        asynchronous active-low reset
//   start          request, sampled only in IDLE (with mode, x_in, y_in, z_in)
//   mode           0 = rotation, 1 = vectoring
//   x_in, y_in     initial vector, W-bit signed
//   z_in           rotation angle, ZW-bit signed (ignored in vectoring)
//   busy           high while a computation is in progress
//   done           one-cycle result-valid pulse
//   x_out, y_out   saturated result vector, held until the next done
//   z_out          residual angle (rotation) or atan2 (vectoring)
module cordic_iter #(
    parameter int W      = 16,
    parameter int ZW     = 18,
    parameter int N_ITER = 14
) (
    input  logic                 CLK,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 mode,
    input  logic signed [W-1:0]  x_in,
    input  logic signed [W-1:0]  y_in,
    input  logic signed [ZW-1:0] z_in,
    output logic                 busy,
    output logic                 done,
    output logic signed [W-1:0]  x_out,
    output logic signed [W-1:0]  y_out,
    output logic signed [ZW-1:0] z_out
);

    localparam int XW = W + 2;
    localparam int IW = $clog2(N_ITER);
    localparam logic signed [ZW-1:0] Z90 = ZW'(23040);

    typedef enum logic [1:0] {IDLE, PRE, ITER, DONE} state_t;

    state_t               state, state_nxt;
    logic signed [XW-1:0] x_r, y_r, x_nxt, y_nxt, x_sh, y_sh;
    logic signed [ZW-1:0] z_r, z_nxt;
    logic [IW-1:0]        iter;
    logic                 vec;
    logic                 d_pos;

    // round(atan(2^-i) * 180/pi * 256); entries past i=14 round to zero.
    function automatic int atan_val(input int i);
        case (i)
            0:       return 11520;
            1:       return 6801;
            2:       return 3593;
            3:       return 1824;
            4:       return 916;
            5:       return 458;
            6:       return 229;
            7:       return 115;
            8:       return 57;
            9:       return 29;
            10:      return 14;
            11:      return 7;
            12:      return 4;
            13:      return 2;
            14:      return 1;
            default: return 0;
        endcase
    endfunction

    // Clip the W+2-bit internal value to the W-bit output range.
    function automatic logic signed [W-1:0] sat(input logic signed [XW-1:0] v);
        if (v[XW-1:W-1] == 3'b000 || v[XW-1:W-1] == 3'b111)
            return v[W-1:0];
        else if (v[XW-1])
            return {1'b1, {(W-1){1'b0}}};
        else
            return {1'b0, {(W-1){1'b1}}};
    endfunction

    logic signed [ZW-1:0] atan_tab [N_ITER];
    for (genvar g = 0; g < N_ITER; g++) begin : g_atan
        assign atan_tab[g] = ZW'(atan_val(g));
    end

    // One micro-rotation from the current (pre-update) register values.
    always_comb begin
        d_pos = vec ? y_r[XW-1] : ~z_r[ZW-1];
        x_sh  = x_r >>> iter;
        y_sh  = y_r >>> iter;
        if (d_pos) begin
            x_nxt = x_r - y_sh;
            y_nxt = y_r + x_sh;
            z_nxt = z_r - atan_tab[iter];
        end else begin
            x_nxt = x_r + y_sh;
            y_nxt = y_r - x_sh;
            z_nxt = z_r + atan_tab[iter];
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        case (state)
            IDLE: if (start) state_nxt = PRE;
            PRE:  state_nxt = ITER;
            ITER: if (iter == IW'(N_ITER - 1)) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            x_r   <= '0;
            y_r   <= '0;
            z_r   <= '0;
            iter  <= '0;
            vec   <= 1'b0;
            done  <= 1'b0;
            x_out <= '0;
            y_out <= '0;
            z_out <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        x_r  <= {{2{x_in[W-1]}}, x_in};
                        y_r  <= {{2{y_in[W-1]}}, y_in};
                        z_r  <= z_in;
                        vec  <= mode;
                        iter <= '0;
                    end
                end
                PRE: begin
                    // Fold the vector into the right half-plane (vectoring) or
                    // the angle into [-90,+90] (rotation) so the series converges.
                    if (vec) begin
                        z_r <= '0;
                        if (x_r[XW-1]) begin
                            if (!y_r[XW-1]) begin
                                x_r <= y_r;
                                y_r <= -x_r;
                                z_r <= Z90;
                            end else begin
                                x_r <= -y_r;
                                y_r <= x_r;
                                z_r <= -Z90;
                            end
                        end
                    end else if (z_r > Z90) begin
                        x_r <= -y_r;
                        y_r <= x_r;
                        z_r <= z_r - Z90;
                    end else if (z_r < -Z90) begin
                        x_r <= y_r;
                        y_r <= -x_r;
                        z_r <= z_r + Z90;
                    end
                end
                ITER: begin
                    x_r  <= x_nxt;
                    y_r  <= y_nxt;
                    z_r  <= z_nxt;
                    iter <= iter + IW'(1);
                end
                DONE: begin
                    x_out <= sat(x_r);
                    y_out <= sat(y_r);
                    z_out <= z_r;
                    done  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_iter.sv
// tb_cordic_iter: directed checks of cordic_iter (W=16, ZW=18, N_ITER=14).
module tb_cordic_iter;

    logic                CLK = 1'b0;
    logic                reset_n;
    logic                start;
    logic                mode;
    logic signed [15:0]  x_in, y_in;
    logic signed [17:0]  z_in;
    logic                busy, done;
    logic signed [15:0]  x_out, y_out;
    logic signed [17:0]  z_out;

    int n_err = 0;
    int n_chk = 0;

    cordic_iter #(.W(16), .ZW(18), .N_ITER(14)) dut (
        .CLK     (CLK),
        .reset_n (reset_n),
        .start   (start),
        .mode    (mode),
        .x_in    (x_in),
        .y_in    (y_in),
        .z_in    (z_in),
        .busy    (busy),
        .done    (done),
        .x_out   (x_out),
        .y_out   (y_out),
        .z_out   (z_out)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_chk++;
        assert (obs === exp_v)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic chk_tol(input string tag, input int obs, input int exp_v, input int tol);
        logic ok;
        ok = (obs >= exp_v - tol) && (obs <= exp_v + tol);
        n_chk++;
        assert (ok === 1'b1)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d+-%0d", tag, obs, exp_v, tol);
        end
    endtask

    // Issue one request and follow it to its done pulse.
    task automatic run_op(input logic m, input int xi, input int yi, input int zi,
                          input string tag);
        int lat;
        mode  = m;
        x_in  = 16'(xi);
        y_in  = 16'(yi);
        z_in  = 18'(zi);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy"}, int'(busy), 1);
        lat = 0;
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            tick();
            if (done === 1'b1) lat = c;
        end
        chk({tag, "_latency"}, lat, 16);
        chk({tag, "_busy_at_done"}, int'(busy), 0);
        tick();
        chk({tag, "_done_pulse"}, int'(done), 0);
    endtask

    initial begin
        int lat, n, first_done, second_done, mism;

        reset_n = 1'b0;
        start   = 1'b0;
        mode    = 1'b0;
        x_in    = '0;
        y_in    = '0;
        z_in    = '0;
        repeat (3) tick();
        chk("rst_busy",  int'(busy), 0);
        chk("rst_done",  int'(done), 0);
        chk("rst_x_out", int'(x_out), 0);
        chk("rst_y_out", int'(y_out), 0);
        chk("rst_z_out", int'(z_out), 0);
        reset_n = 1'b1;
        tick();

        // 30 deg rotation of 19898 (= 32768/K)
        run_op(1'b0, 19898, 0, 7680, "rot30");
        chk_tol("rot30_x", int'(x_out), 28377, 8);
        chk_tol("rot30_y", int'(y_out), 16384, 8);
        chk_tol("rot30_z", int'(z_out), 0, 4);

        // 150 deg and -150 deg exercise the pre-rotation quadrant fold
        run_op(1'b0, 19898, 0, 38400, "rot150");
        chk_tol("rot150_x", int'(x_out), -28377, 8);
        chk_tol("rot150_y", int'(y_out), 16384, 8);

        run_op(1'b0, 19898, 0, -38400, "rotm150");
        chk_tol("rotm150_x", int'(x_out), -28377, 8);
        chk_tol("rotm150_y", int'(y_out), -16384, 8);

        // vectoring: 45 deg, 180 deg, -135 deg
        run_op(1'b1, 10000, 10000, 0, "vec45");
        chk_tol("vec45_z", int'(z_out), 11520, 16);
        chk_tol("vec45_x", int'(x_out), 23290, 8);
        chk_tol("vec45_y", int'(y_out), 0, 4);

        run_op(1'b1, -10000, 0, 0, "vec180");
        chk_tol("vec180_z", int'(z_out), 46080, 16);
        chk_tol("vec180_x", int'(x_out), 16468, 8);

        run_op(1'b1, -10000, -10000, 0, "vecm135");
        chk_tol("vecm135_z", int'(z_out), -34560, 16);
        chk_tol("vecm135_x", int'(x_out), 23290, 8);

        // saturation: K*32767 does not fit in 16 bits
        run_op(1'b0, 32767, 32767, 0, "sat");
        chk("sat_x", int'(x_out), 32767);
        chk("sat_y", int'(y_out), 32767);

        // start pulses while busy must be ignored
        mode  = 1'b0;
        x_in  = 16'(19898);
        y_in  = '0;
        z_in  = 18'(7680);
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            tick();
            if (c == 3 || c == 10) begin
                x_in  = 16'(1000);
                z_in  = '0;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) lat = c;
        end
        start = 1'b0;
        chk("ign_latency", lat, 16);
        chk_tol("ign_x", int'(x_out), 28377, 8);
        chk_tol("ign_y", int'(y_out), 16384, 8);
        n = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (done === 1'b1) n++;
        end
        chk("ign_no_extra_done", n, 0);

        // start held high: accepts every N_ITER+3 cycles, including on done
        x_in  = 16'(19898);
        y_in  = '0;
        z_in  = 18'(7680);
        start = 1'b1;
        tick();
        first_done  = 0;
        second_done = 0;
        mism        = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (done === 1'b1) begin
                if (first_done == 0) first_done = c;
                else if (second_done == 0) second_done = c;
            end
            if (busy === done) mism++;
        end
        start = 1'b0;
        chk("b2b_first_done", first_done, 16);
        chk("b2b_second_done", second_done, 33);
        chk("b2b_busy_vs_idle", mism, 0);
        lat = 0;
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            tick();
            if (done === 1'b1) lat = c;
        end
        chk("b2b_third_done", lat, 10);
        tick();
        chk_tol("b2b_x", int'(x_out), 28377, 8);

        // reset in the middle of an operation
        mode  = 1'b0;
        x_in  = 16'(19898);
        y_in  = '0;
        z_in  = 18'(38400);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        reset_n = 1'b0;
        #1;
        chk("mid_rst_x_out", int'(x_out), 0);
        chk("mid_rst_y_out", int'(y_out), 0);
        chk("mid_rst_z_out", int'(z_out), 0);
        chk("mid_rst_busy",  int'(busy), 0);
        chk("mid_rst_done",  int'(done), 0);
        repeat (2) tick();
        reset_n = 1'b1;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (done === 1'b1) n++;
        end
        chk("mid_rst_no_done", n, 0);

        run_op(1'b0, 19898, 0, 7680, "post_rst");
        chk_tol("post_rst_x", int'(x_out), 28377, 8);
        chk_tol("post_rst_y", int'(y_out), 16384, 8);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
